// File: rtl/phy_cfg_pkg.sv
// phy_cfg_pkg: shared types and default configuration table for the PHY
// configuration sequencer.
// Build option: PHY_CFG_POLL_EN (consumed by phy_cfg_seq) enables the
// post-write status polling phase.
package phy_cfg_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_POLL  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } cfg_state_t;

    // One configuration-table entry: PHY register address and write data
    typedef struct packed {
        logic [4:0]  addr;
        logic [15:0] data;
    } cfg_entry_t;

    // Default table: soft reset, advertise 10/100, restart autoneg, 1000BASE-T ctrl
    localparam cfg_entry_t ENTRY_0 = '{addr: 5'd0, data: 16'h8000};
    localparam cfg_entry_t ENTRY_1 = '{addr: 5'd4, data: 16'h01E1};
    localparam cfg_entry_t ENTRY_2 = '{addr: 5'd0, data: 16'h1200};
    localparam cfg_entry_t ENTRY_3 = '{addr: 5'd9, data: 16'h0000};
    localparam cfg_entry_t ENTRY_NONE = '{addr: 5'd0, data: 16'h0000};

    // Table lookup; indices beyond the populated table read as all-zero
    function automatic cfg_entry_t default_entry(input logic [3:0] idx);
        cfg_entry_t e;
        case (idx)
            4'd0:    e = ENTRY_0;
            4'd1:    e = ENTRY_1;
            4'd2:    e = ENTRY_2;
            4'd3:    e = ENTRY_3;
            default: e = ENTRY_NONE;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/phy_cfg_rom.sv
// phy_cfg_rom: combinational index-to-entry lookup into the default
// configuration table.
module phy_cfg_rom
    import phy_cfg_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic [IDX_W-1:0] idx,
    output cfg_entry_t       entry
);

    // Pure table lookup, no state
    always_comb begin
        entry = default_entry(4'(idx));
    end

endmodule

// File: rtl/phy_cfg_seq.sv
// phy_cfg_seq: writes a table of PHY registers over a management
// controller, optionally polls PHY status until ready, and flags
// completion, timeout and link state. All outputs are registered and are
// computed from the next state so they are valid in the cycle a state is
// entered.
// Build option: define PHY_CFG_POLL_EN to include the POLL/GAP status
// polling phase; without it the last write completes the run directly.
module phy_cfg_seq
    import phy_cfg_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int POLL_GAP    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        write_over,
    input  logic        mdio_ready,
    output logic        mdio_init,
    output logic [4:0]  reg_addr,
    output logic [15:0] data,
    output logic        status_req,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_timeout,
    output logic        link_up
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};

    cfg_state_t       state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [TMR_W-1:0] tmr_r, tmr_s;
    logic             done_s, timeout_s, link_s;
    logic             init_s, busy_s, status_s;
    logic [4:0]       addr_s;
    logic [15:0]      data_s;
    cfg_entry_t       rom_entry_s;

`ifdef PHY_CFG_POLL_EN
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
    logic [GAP_W-1:0] gap_r, gap_s;
`else
    // Status is never read in this build
    logic unused_mdio_ready_s;
    assign unused_mdio_ready_s = mdio_ready;
`endif

    // Entry for the index that will be current after this edge
    phy_cfg_rom #(.IDX_W(IDX_W)) u_rom (
        .idx   (idx_s),
        .entry (rom_entry_s)
    );

    // Next-state, index, frame timer and sticky-flag logic
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        tmr_s     = {TMR_W{1'b0}};
        done_s    = cfg_done;
        timeout_s = cfg_timeout;
        link_s    = link_up;
`ifdef PHY_CFG_POLL_EN
        gap_s     = {GAP_W{1'b0}};
`endif
        case (state_r)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_s   = ST_WRITE;
                    idx_s     = {IDX_W{1'b0}};
                    done_s    = 1'b0;
                    timeout_s = 1'b0;
                    link_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_WRITE: begin
                if (write_over) begin
                    // Timer restarts for the next frame (default above)
                    if (idx_r != IDX_LAST) begin
                        idx_s = idx_r + IDX_W'(1'b1);
                    end else begin
`ifdef PHY_CFG_POLL_EN
                        state_s = ST_POLL;
`else
                        state_s = ST_DONE;
                        done_s  = 1'b1;
`endif
                    end
                end else if (tmr_r == TMR_LIMIT) begin
                    state_s   = ST_FAIL;
                    timeout_s = 1'b1;
                end else begin
                    tmr_s = (tmr_r == TMR_MAX) ? tmr_r : tmr_r + TMR_W'(1'b1);
                end
            end
`ifdef PHY_CFG_POLL_EN
            ST_POLL: begin
                if (write_over) begin
                    state_s = ST_GAP;
                end else if (tmr_r == TMR_LIMIT) begin
                    state_s   = ST_FAIL;
                    timeout_s = 1'b1;
                end else begin
                    tmr_s = (tmr_r == TMR_MAX) ? tmr_r : tmr_r + TMR_W'(1'b1);
                end
            end
            ST_GAP: begin
                // Status is only trusted on the first cycle after the read frame
                if ((gap_r == {GAP_W{1'b0}}) && mdio_ready) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    link_s  = 1'b1;
                end else if (gap_r == GAP_LAST) begin
                    state_s = ST_POLL;
                end else begin
                    gap_s = gap_r + GAP_W'(1'b1);
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
`ifndef PHY_CFG_POLL_EN
        link_s = 1'b0;
`endif
    end

    // Output decode from the next state so registered outputs line up with it
    always_comb begin
        init_s = (state_s == ST_WRITE);
        busy_s = (state_s == ST_WRITE) || (state_s == ST_POLL) || (state_s == ST_GAP);
        if (init_s) begin
            addr_s = rom_entry_s.addr;
            data_s = rom_entry_s.data;
        end else begin
            addr_s = 5'd0;
            data_s = 16'h0000;
        end
`ifdef PHY_CFG_POLL_EN
        status_s = (state_s == ST_POLL);
`else
        status_s = 1'b0;
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            tmr_r       <= {TMR_W{1'b0}};
            mdio_init   <= 1'b0;
            reg_addr    <= 5'd0;
            data        <= 16'h0000;
            status_req  <= 1'b0;
            cfg_busy    <= 1'b0;
            cfg_done    <= 1'b0;
            cfg_timeout <= 1'b0;
            link_up     <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            tmr_r       <= tmr_s;
            mdio_init   <= init_s;
            reg_addr    <= addr_s;
            data        <= data_s;
            status_req  <= status_s;
            cfg_busy    <= busy_s;
            cfg_done    <= done_s;
            cfg_timeout <= timeout_s;
            link_up     <= link_s;
        end
    end

`ifdef PHY_CFG_POLL_EN
    // Poll gap counter
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_r <= {GAP_W{1'b0}};
        end else begin
            gap_r <= gap_s;
        end
    end
`endif

endmodule

// File: tb/tb_phy_cfg_seq.sv
// tb_phy_cfg_seq: directed and randomized stimulus for phy_cfg_seq,
// checked every cycle against a behavioural model built on cycle stamps,
// plus literal expectations for the key scenarios.
// Honours PHY_CFG_POLL_EN the same way as the design.
module tb_phy_cfg_seq;

    localparam int NR = 4;
    localparam int TO = 4096;
    localparam int PG = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        write_over = 1'b0;
    logic        mdio_ready = 1'b0;
    logic        mdio_init;
    logic [4:0]  reg_addr;
    logic [15:0] data;
    logic        status_req;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_timeout;
    logic        link_up;

    phy_cfg_seq #(.NUM_REGS(NR), .TIMEOUT_CYC(TO), .POLL_GAP(PG)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .write_over  (write_over),
        .mdio_ready  (mdio_ready),
        .mdio_init   (mdio_init),
        .reg_addr    (reg_addr),
        .data        (data),
        .status_req  (status_req),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_timeout (cfg_timeout),
        .link_up     (link_up)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;
    bit check_en = 1'b0;

    // Expected configuration table
    logic [4:0]  ref_addr [NR] = '{5'd0, 5'd4, 5'd0, 5'd9};
    logic [15:0] ref_data [NR] = '{16'h8000, 16'h01E1, 16'h1200, 16'h0000};

    // Behavioural model: run phase plus cycle stamps of frame / gap start
    localparam int M_IDLE = 0, M_WRITING = 1, M_POLLING = 2, M_WAITING = 3,
                   M_DONE = 4, M_FAILED = 5;
    int     phase = M_IDLE;
    int     entry = 0;
    longint cyc = 0;
    longint frame_t0 = 0;
    longint gap_t0 = 0;
    bit     m_done = 1'b0, m_tmo = 1'b0, m_link = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            phase <= M_IDLE; entry <= 0;
            m_done <= 1'b0; m_tmo <= 1'b0; m_link <= 1'b0;
        end else if (phase == M_IDLE || phase == M_DONE || phase == M_FAILED) begin
            if (start) begin
                phase <= M_WRITING; entry <= 0; frame_t0 <= cyc;
                m_done <= 1'b0; m_tmo <= 1'b0; m_link <= 1'b0;
            end
        end else if (phase == M_WRITING) begin
            if (write_over) begin
                frame_t0 <= cyc;
                if (entry < NR - 1) begin
                    entry <= entry + 1;
                end else begin
`ifdef PHY_CFG_POLL_EN
                    phase <= M_POLLING;
`else
                    phase <= M_DONE; m_done <= 1'b1;
`endif
                end
            end else if (cyc - frame_t0 >= TO) begin
                phase <= M_FAILED; m_tmo <= 1'b1;
            end
        end else if (phase == M_POLLING) begin
            if (write_over) begin
                phase <= M_WAITING; gap_t0 <= cyc;
            end else if (cyc - frame_t0 >= TO) begin
                phase <= M_FAILED; m_tmo <= 1'b1;
            end
        end else if (phase == M_WAITING) begin
            if (cyc - gap_t0 == 1 && mdio_ready) begin
                phase <= M_DONE; m_done <= 1'b1; m_link <= 1'b1;
            end else if (cyc - gap_t0 >= PG) begin
                phase <= M_POLLING; frame_t0 <= cyc;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin : cmp
        logic [26:0] got;
        logic [26:0] exp;
        if (check_en) begin
            got = {mdio_init, reg_addr, data, status_req, cfg_busy, cfg_done, cfg_timeout, link_up};
            exp[26]    = (phase == M_WRITING);
            exp[25:21] = (phase == M_WRITING) ? ref_addr[entry] : 5'd0;
            exp[20:5]  = (phase == M_WRITING) ? ref_data[entry] : 16'h0000;
            exp[4]     = (phase == M_POLLING);
            exp[3]     = (phase == M_WRITING) || (phase == M_POLLING) || (phase == M_WAITING);
            exp[2]     = m_done;
            exp[1]     = m_tmo;
            exp[0]     = m_link;
            vectors++;
            if (got !== exp) begin
                miscompares++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL cycle_model t=%0t got=%07h expected=%07h", $time, got, exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic pulse_wo();
        write_over = 1'b1; tick(1); write_over = 1'b0;
    endtask

    initial begin
        int len;
        int mode;
        rst = 1'b1;
        tick(2);
        check_en = 1'b1;
        check_lit("reset_init",  32'(mdio_init), 32'd0);
        check_lit("reset_addr",  32'(reg_addr),  32'd0);
        check_lit("reset_busy",  32'(cfg_busy),  32'd0);
        check_lit("reset_flags", 32'({cfg_done, cfg_timeout, link_up}), 32'd0);
        rst = 1'b0;
        tick(2);

        // write_over in IDLE is ignored
        pulse_wo();
        check_lit("idle_wo_busy", 32'(cfg_busy), 32'd0);

        // Start a run; entry 0 visible in the first WRITE cycle
        start = 1'b1; tick(1); start = 1'b0;
        check_lit("e0_init", 32'(mdio_init), 32'd1);
        check_lit("e0_addr", 32'(reg_addr),  32'd0);
        check_lit("e0_data", 32'(data),      32'h8000);

        for (int e = 0; e < NR; e++) begin
            if (e == 1) begin
                tick(30); start = 1'b1; tick(1); start = 1'b0; tick(32);
            end else begin
                tick(63);
            end
            pulse_wo();
            if (e == 0) begin
                check_lit("e1_addr", 32'(reg_addr), 32'd4);
                check_lit("e1_data", 32'(data),     32'h01E1);
            end
            if (e == 1) begin
                check_lit("e2_addr_after_start", 32'(reg_addr), 32'd0);
                check_lit("e2_data_after_start", 32'(data),     32'h1200);
            end
        end

`ifdef PHY_CFG_POLL_EN
        check_lit("poll_status", 32'(status_req), 32'd1);
        check_lit("poll_init",   32'(mdio_init),  32'd0);
        mdio_ready = 1'b0;
        tick(20);
        pulse_wo();
        check_lit("gap_status", 32'(status_req), 32'd0);
        check_lit("gap_busy",   32'(cfg_busy),   32'd1);
        tick(PG - 1);
        check_lit("gap_last_idle", 32'(status_req), 32'd0);
        tick(1);
        check_lit("repoll_status", 32'(status_req), 32'd1);
        mdio_ready = 1'b1;
        tick(10);
        pulse_wo();
        tick(1);
        check_lit("poll_done", 32'(cfg_done), 32'd1);
        check_lit("poll_link", 32'(link_up),  32'd1);
        check_lit("poll_idle", 32'(cfg_busy), 32'd0);
        mdio_ready = 1'b0;
`else
        check_lit("nopoll_done",   32'(cfg_done),   32'd1);
        check_lit("nopoll_busy",   32'(cfg_busy),   32'd0);
        check_lit("nopoll_init",   32'(mdio_init),  32'd0);
        check_lit("nopoll_status", 32'(status_req), 32'd0);
        check_lit("nopoll_link",   32'(link_up),    32'd0);
`endif
        tick(3);

        // Reset while entry 2 is presented
        start = 1'b1; tick(1); start = 1'b0;
        tick(3); pulse_wo(); tick(2); pulse_wo();
        check_lit("rst_pre_addr", 32'(reg_addr), 32'd0);
        check_lit("rst_pre_data", 32'(data),     32'h1200);
        tick(5);
        rst = 1'b1; tick(1); rst = 1'b0;
        check_lit("rst_all_zero", 32'({mdio_init, reg_addr, data, status_req, cfg_busy,
                                       cfg_done, cfg_timeout, link_up}), 32'd0);
        tick(2);
        start = 1'b1; tick(1); start = 1'b0;
        check_lit("restart_addr", 32'(reg_addr), 32'd0);
        check_lit("restart_data", 32'(data),     32'h8000);

        // Timeout on entry 1
        pulse_wo();
        check_lit("tmo_e1_addr", 32'(reg_addr), 32'd4);
        tick(TO - 1);
        check_lit("tmo_not_yet", 32'(cfg_timeout), 32'd0);
        check_lit("tmo_init_hi", 32'(mdio_init),   32'd1);
        tick(1);
        check_lit("tmo_flag", 32'(cfg_timeout), 32'd1);
        check_lit("tmo_init", 32'(mdio_init),   32'd0);
        check_lit("tmo_busy", 32'(cfg_busy),    32'd0);
        pulse_wo();
        check_lit("fail_wo_ignored", 32'({cfg_busy, cfg_timeout}), 32'd1);
        start = 1'b1; tick(1); start = 1'b0;
        check_lit("rerun_data", 32'(data),        32'h8000);
        check_lit("rerun_tmo",  32'(cfg_timeout), 32'd0);

        // Randomized traffic in chunks of differing write_over density
        for (int c = 0; c < 16; c++) begin
            len  = $urandom_range(3000, 100);
            mode = $urandom_range(2, 0);
            for (int i = 0; i < len; i++) begin
                rst        = ($urandom_range(2999, 0) == 0);
                start      = ($urandom_range(99, 0) == 0);
                write_over = (mode == 0) ? ($urandom_range(7, 0) == 0) :
                             (mode == 1) ? ($urandom_range(63, 0) == 0) : 1'b0;
                mdio_ready = ($urandom_range(3, 0) == 0);
                tick(1);
            end
        end
        rst = 1'b0; write_over = 1'b0; mdio_ready = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(TO + 100);

        check_en = 1'b0;
        tick(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/phy_cfg_seq.md
PHY_CFG_SEQ -- requirements
Module: phy_cfg_seq

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 4: number of configuration-table entries written per run (1..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles allowed per management frame without write_over.
REQ-003 The block SHALL have parameter POLL_GAP, default 256: idle cycles between consecutive status polls.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a configuration run.
REQ-007 write_over  in  1  pulse from the management controller marking the end of a frame.
REQ-008 mdio_ready  in  1  PHY status LSB returned by the management controller.
REQ-009 mdio_init  out  1  write-session request; held high across all table writes.
REQ-010 reg_addr  out  5  register address of the current entry.
REQ-011 data  out  16  write data of the current entry.
REQ-012 status_req  out  1  status-read request.
REQ-013 cfg_busy  out  1  high while a run is in progress.
REQ-014 cfg_done  out  1  sticky; the run completed successfully.
REQ-015 cfg_timeout  out  1  sticky; a frame exceeded TIMEOUT_CYC.
REQ-016 link_up  out  1  sticky; PHY reported ready.

Function
REQ-017 FSM states SHALL be IDLE, WRITE, POLL, GAP, DONE and FAIL; all outputs SHALL be registered.
REQ-018 In IDLE, DONE or FAIL, start SHALL move the FSM to WRITE on the next edge with index=0 and clear cfg_done, cfg_timeout and link_up.
REQ-019 start SHALL be ignored in WRITE, POLL and GAP.
REQ-020 In WRITE, the outputs SHALL be mdio_init=1, reg_addr=ROM[index].addr and data=ROM[index].data, valid in the same cycle the state is entered.
REQ-021 On write_over in WRITE with index<NUM_REGS-1, index SHALL increment and the next entry SHALL be presented on the following cycle, with mdio_init held high without a gap.
REQ-022 On write_over in WRITE with index==NUM_REGS-1, mdio_init SHALL drop on the next cycle and the FSM SHALL go to POLL.
REQ-023 In POLL, the outputs SHALL be status_req=1 and mdio_init=0; on write_over the FSM SHALL go to GAP with status_req=0.
REQ-024 On the first GAP cycle, mdio_ready SHALL be sampled; if 1, the FSM SHALL go to DONE and set link_up=1 and cfg_done=1.
REQ-025 If the GAP sample is 0, the FSM SHALL count POLL_GAP cycles and then return to POLL; polling is unbounded.
REQ-026 The frame timer SHALL clear on entering WRITE/POLL and on each write_over; reaching TIMEOUT_CYC-1 in WRITE or POLL SHALL go to FAIL with cfg_timeout=1, mdio_init=0 and status_req=0.
REQ-027 write_over SHALL be ignored in IDLE, GAP, DONE and FAIL.
REQ-028 cfg_busy SHALL be 1 exactly in WRITE, POLL and GAP.
REQ-029 The index SHALL be $clog2(NUM_REGS) bits wide and SHALL never wrap.
REQ-030 The timer SHALL be $clog2(TIMEOUT_CYC) bits wide and SHALL saturate.

Reset
REQ-031 rst, including mid-frame, SHALL force IDLE, index=0, timers=0 and all outputs 0 (reg_addr=0, data=0) on the next edge.

Configuration
REQ-032 With PHY_CFG_POLL_EN defined, the POLL and GAP states SHALL exist as described above.
REQ-033 Without PHY_CFG_POLL_EN, the final write_over SHALL go directly to DONE with cfg_done=1, link_up SHALL be tied 0 and status_req SHALL be tied 0.

Structure
REQ-034 Package phy_cfg_pkg SHALL hold the state enum, the table-entry struct {addr[4:0], data[15:0]} and the default table constants.
REQ-035 The default table SHALL be: 0 = reg0/0x8000, 1 = reg4/0x01E1, 2 = reg0/0x1200, 3 = reg9/0x0000.
REQ-036 Sub-module phy_cfg_rom SHALL be a combinational index-to-entry lookup.

Verification
REQ-037 start pulse, write_over every 64 cycles -> entries 0..3 presented in order, mdio_init high continuously, then status_req=1.
REQ-038 Poll with mdio_ready=0 then 1 -> two POLL frames separated by 256 idle cycles; then cfg_done=1 and link_up=1.
REQ-039 No write_over for 4096 cycles in WRITE index 1 -> cfg_timeout=1, mdio_init=0, FSM in FAIL; a later start reruns from entry 0.
REQ-040 start pulsed during WRITE, and write_over in IDLE -> no effect on index or state.
REQ-041 rst asserted during entry 2 -> all outputs 0 on the next cycle; a subsequent start begins at entry 0.
REQ-042 Build without PHY_CFG_POLL_EN -> cfg_done=1 one cycle after the 4th write_over, and status_req never asserted.
